// File: rtl/stack_sequencer.sv
// Fetch/decode control for a small stack machine: reads a combinational program ROM,
// drives the 8-deep negedge stack and emits a result stream plus halt/error status.
module stack_sequencer #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  resetN,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic [WIDTH+3:0]      instr,
    output logic                  stack_push,
    output logic                  stack_pop,
    output logic [WIDTH-1:0]      stack_din,
    input  logic [WIDTH-1:0]      stack_dout,
    input  logic                  stack_full,
    input  logic                  stack_empty,
    output logic [WIDTH-1:0]      result,
    output logic                  result_valid,
    output logic                  halted,
    output logic                  error
);

    typedef enum logic [3:0] {
        FETCH, DECODE, PUSH_IMM, POP_A, POP_B, ALU_PUSH, OUT_POP, JZ_POP, HALT, ERROR
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_PUSH = 4'h1;
    localparam logic [3:0] OP_OUT  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [WIDTH+3:0]        ir;
    logic [WIDTH-1:0]        a_reg;

    logic [3:0]              opcode;
    logic [WIDTH-1:0]        imm;
    logic [ADDR_WIDTH-1:0]   jump_target;

    assign opcode      = ir[WIDTH+3:WIDTH];
    assign imm         = ir[WIDTH-1:0];
    assign jump_target = imm[ADDR_WIDTH-1:0];
    assign instr_addr  = pc;

    // Stack requests are one-cycle Moore levels of the state register, settled well before
    // the stack samples them on the falling edge; there is no back-pressure, so the flags
    // are checked in DECODE/POP_A before any request that the stack would have to ignore.
    assign stack_push = (state == PUSH_IMM) || (state == ALU_PUSH);
    assign stack_pop  = (state == POP_A) || (state == POP_B) ||
                        (state == OUT_POP) || (state == JZ_POP);
    assign halted     = (state == HALT) || (state == ERROR);
    assign error      = (state == ERROR);

    function automatic logic [WIDTH-1:0] alu(input logic [3:0] op,
                                             input logic [WIDTH-1:0] b,
                                             input logic [WIDTH-1:0] a);
        case (op)
            OP_ADD:  alu = b + a;
            OP_SUB:  alu = b - a;
            OP_AND:  alu = b & a;
            OP_OR:   alu = b | a;
            default: alu = b ^ a;
        endcase
    endfunction

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= FETCH;
            pc           <= '0;
            ir           <= '0;
            a_reg        <= '0;
            stack_din    <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                FETCH: begin
                    ir    <= instr;
                    pc    <= pc + 1'b1;
                    state <= DECODE;
                end
                DECODE: begin
                    case (opcode)
                        OP_NOP:  state <= FETCH;
                        OP_JMP: begin
                            pc    <= jump_target;
                            state <= FETCH;
                        end
                        OP_HALT: state <= HALT;
                        OP_PUSH: begin
                            if (stack_full) begin
                                state <= ERROR;
                            end else begin
                                stack_din <= imm;
                                state     <= PUSH_IMM;
                            end
                        end
                        OP_OUT:  state <= stack_empty ? ERROR : OUT_POP;
                        OP_JZ:   state <= stack_empty ? ERROR : JZ_POP;
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                                 state <= stack_empty ? ERROR : POP_A;
                        default: state <= ERROR;
                    endcase
                end
                PUSH_IMM: state <= FETCH;
                POP_A: begin
                    // stack_dout now holds the top (A); an empty stack means B is missing.
                    a_reg <= stack_dout;
                    state <= stack_empty ? ERROR : POP_B;
                end
                POP_B: begin
                    stack_din <= alu(opcode, stack_dout, a_reg);
                    state     <= ALU_PUSH;
                end
                ALU_PUSH: state <= FETCH;
                OUT_POP: begin
                    result       <= stack_dout;
                    result_valid <= 1'b1;
                    state        <= FETCH;
                end
                JZ_POP: begin
                    if (stack_dout == '0) pc <= jump_target;
                    state <= FETCH;
                end
                HALT:    state <= HALT;
                ERROR:   state <= ERROR;
                default: state <= ERROR;
            endcase
        end
    end

endmodule
